// File: rtl/branch_predictor_2lvl.sv
// Two-level local branch predictor: hashed per-branch history table feeding a PC+history indexed
// table of saturating counters, with a post-reset clear sweep, update forwarding and perf counters.
module branch_predictor_2lvl #(
   parameter  int PC_W      = 32,
   parameter  int BHT_IDX_W = 4,
   parameter  int HIST_W    = 4,
   parameter  int PHT_PC_W  = 3,
   parameter  int PC_LSB    = 0,
   parameter  int CTR_W     = 2,
   parameter  int INIT_CTR  = 2,
   localparam int PHT_IDX_W = PHT_PC_W + HIST_W
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 ready,
   input  logic                 pred_req,
   input  logic [PC_W-1:0]      pc,
   output logic                 pred_valid,
   output logic                 pred_taken,
   output logic [BHT_IDX_W-1:0] pred_bht_index,
   output logic [PHT_IDX_W-1:0] pred_pht_index,
   output logic [HIST_W-1:0]    pred_bhr,
   input  logic                 upd_valid,
   input  logic [BHT_IDX_W-1:0] upd_bht_index,
   input  logic [PHT_IDX_W-1:0] upd_pht_index,
   input  logic                 upd_taken,
   input  logic                 upd_mispredict,
   output logic [31:0]          perf_lookups,
   output logic [31:0]          perf_mispredicts
);

   localparam int BHT_DEPTH = 1 << BHT_IDX_W;
   localparam int PHT_DEPTH = 1 << PHT_IDX_W;
   localparam int PTR_W     = (BHT_IDX_W > PHT_IDX_W) ? BHT_IDX_W : PHT_IDX_W;
   localparam int NCHUNK    = (PC_W + BHT_IDX_W - 1) / BHT_IDX_W;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     clr_ptr_q, clr_ptr_d;

   logic [HIST_W-1:0]    bht_q [BHT_DEPTH];
   logic [CTR_W-1:0]     pht_q [PHT_DEPTH];

   logic                 pred_valid_q, pred_valid_d;
   logic                 pred_taken_q, pred_taken_d;
   logic [BHT_IDX_W-1:0] pred_bht_q, pred_bht_d;
   logic [PHT_IDX_W-1:0] pred_pht_q, pred_pht_d;
   logic [HIST_W-1:0]    pred_bhr_q, pred_bhr_d;
   logic [31:0]          perf_lookups_q, perf_lookups_d;
   logic [31:0]          perf_mispredicts_q, perf_mispredicts_d;

   logic                 run, pred_fire, upd_fire;
   logic [HIST_W:0]      upd_bhr_shift;
   logic [HIST_W-1:0]    upd_bhr_new;
   logic [CTR_W-1:0]     upd_ctr_new;
   logic [BHT_IDX_W-1:0] lk_bht_idx;
   logic [HIST_W-1:0]    lk_bhr;
   logic [PHT_IDX_W-1:0] lk_pht_idx;
   logic [CTR_W-1:0]     lk_ctr;

   // A partial top chunk is zero-extended naturally by the right shift.
   function automatic logic [BHT_IDX_W-1:0] fold_pc(input logic [PC_W-1:0] v);
      logic [BHT_IDX_W-1:0] acc;
      logic [PC_W-1:0]      t;
      acc = '0;
      t   = v;
      for (int i = 0; i < NCHUNK; i++) begin
         acc = acc ^ t[BHT_IDX_W-1:0];
         t   = t >> BHT_IDX_W;
      end
      return acc;
   endfunction

   function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c, input logic taken);
      if (taken) return (&c)  ? c : c + CTR_W'(1);
      else       return (~|c) ? c : c - CTR_W'(1);
   endfunction

   assign run       = (state_q == ST_RUN);
   assign pred_fire = run & pred_req;
   assign upd_fire  = run & upd_valid;

   // Forwarding makes the lookup see the table contents as they will be after this edge.
   assign upd_bhr_shift = {bht_q[upd_bht_index], upd_taken};
   assign upd_bhr_new   = upd_bhr_shift[HIST_W-1:0];
   assign upd_ctr_new   = ctr_next(pht_q[upd_pht_index], upd_taken);
   assign lk_bht_idx    = fold_pc(pc);
   assign lk_bhr        = (upd_fire && upd_bht_index == lk_bht_idx) ? upd_bhr_new : bht_q[lk_bht_idx];
   assign lk_pht_idx    = {pc[PC_LSB +: PHT_PC_W], lk_bhr};
   assign lk_ctr        = (upd_fire && upd_pht_index == lk_pht_idx) ? upd_ctr_new : pht_q[lk_pht_idx];

   // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      if (state_q == ST_CLEAR) begin
         clr_ptr_d = clr_ptr_q + PTR_W'(1);
         if (&clr_ptr_q) state_d = ST_RUN;
      end
   end

   always_comb begin
      pred_valid_d       = pred_fire;
      pred_taken_d       = pred_taken_q;
      pred_bht_d         = pred_bht_q;
      pred_pht_d         = pred_pht_q;
      pred_bhr_d         = pred_bhr_q;
      perf_lookups_d     = perf_lookups_q;
      perf_mispredicts_d = perf_mispredicts_q;
      if (pred_fire) begin
         pred_taken_d = lk_ctr[CTR_W-1];
         pred_bht_d   = lk_bht_idx;
         pred_pht_d   = lk_pht_idx;
         pred_bhr_d   = lk_bhr;
         if (!(&perf_lookups_q)) perf_lookups_d = perf_lookups_q + 32'd1;
      end
      if (upd_fire && upd_mispredict && !(&perf_mispredicts_q))
         perf_mispredicts_d = perf_mispredicts_q + 32'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= ST_CLEAR;
         clr_ptr_q          <= '0;
         pred_valid_q       <= 1'b0;
         pred_taken_q       <= 1'b0;
         pred_bht_q         <= '0;
         pred_pht_q         <= '0;
         pred_bhr_q         <= '0;
         perf_lookups_q     <= '0;
         perf_mispredicts_q <= '0;
      end else begin
         state_q            <= state_d;
         clr_ptr_q          <= clr_ptr_d;
         pred_valid_q       <= pred_valid_d;
         pred_taken_q       <= pred_taken_d;
         pred_bht_q         <= pred_bht_d;
         pred_pht_q         <= pred_pht_d;
         pred_bhr_q         <= pred_bhr_d;
         perf_lookups_q     <= perf_lookups_d;
         perf_mispredicts_q <= perf_mispredicts_d;
      end
   end

   // NOTE: the tables have no reset branch; the CLEAR sweep initialises them one entry per cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == ST_CLEAR) begin
            if ((clr_ptr_q >> BHT_IDX_W) == '0) bht_q[clr_ptr_q[BHT_IDX_W-1:0]] <= '0;
            if ((clr_ptr_q >> PHT_IDX_W) == '0) pht_q[clr_ptr_q[PHT_IDX_W-1:0]] <= CTR_W'(INIT_CTR);
         end else if (upd_valid) begin
            bht_q[upd_bht_index] <= upd_bhr_new;
            pht_q[upd_pht_index] <= upd_ctr_new;
         end
      end
   end

   assign ready            = run;
   assign pred_valid       = pred_valid_q;
   assign pred_taken       = pred_taken_q;
   assign pred_bht_index   = pred_bht_q;
   assign pred_pht_index   = pred_pht_q;
   assign pred_bhr         = pred_bhr_q;
   assign perf_lookups     = perf_lookups_q;
   assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor_2lvl.sv
// Directed bench for branch_predictor_2lvl: clear sweep, counter saturation, history shift,
// same-cycle forwarding, mid-run reset and performance counters.
module tb_branch_predictor_2lvl;

   logic        clk = 1'b0;
   logic        reset;
   logic        ready;
   logic        pred_req;
   logic [31:0] pc;
   logic        pred_valid;
   logic        pred_taken;
   logic [3:0]  pred_bht_index;
   logic [6:0]  pred_pht_index;
   logic [3:0]  pred_bhr;
   logic        upd_valid;
   logic [3:0]  upd_bht_index;
   logic [6:0]  upd_pht_index;
   logic        upd_taken;
   logic        upd_mispredict;
   logic [31:0] perf_lookups;
   logic [31:0] perf_mispredicts;

   int checks   = 0;
   int failures = 0;
   int run_cycles = 0;
   bit saw_valid;

   branch_predictor_2lvl dut (
      .clk              (clk),
      .reset            (reset),
      .ready            (ready),
      .pred_req         (pred_req),
      .pc               (pc),
      .pred_valid       (pred_valid),
      .pred_taken       (pred_taken),
      .pred_bht_index   (pred_bht_index),
      .pred_pht_index   (pred_pht_index),
      .pred_bhr         (pred_bhr),
      .upd_valid        (upd_valid),
      .upd_bht_index    (upd_bht_index),
      .upd_pht_index    (upd_pht_index),
      .upd_taken        (upd_taken),
      .upd_mispredict   (upd_mispredict),
      .perf_lookups     (perf_lookups),
      .perf_mispredicts (perf_mispredicts)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (ready === 1'b1) run_cycles++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
         $error("check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      pred_req       = 1'b0;
      upd_valid      = 1'b0;
      upd_mispredict = 1'b0;
   endtask

   task automatic drive_pred(input logic [31:0] p);
      pred_req = 1'b1;
      pc       = p;
   endtask

   task automatic drive_upd(input logic [3:0] b, input logic [6:0] ph, input logic t, input logic m);
      upd_valid      = 1'b1;
      upd_bht_index  = b;
      upd_pht_index  = ph;
      upd_taken      = t;
      upd_mispredict = m;
   endtask

   // Advance one cycle with whatever is driven, then return inputs to idle.
   task automatic step();
      @(negedge clk);
      idle();
   endtask

   // Counts cycles with ready low, starting at the negedge after the reset edge.
   task automatic wait_sweep(output int n);
      n = 0;
      saw_valid = 1'b0;
      while (ready !== 1'b1 && n < 1000) begin
         n++;
         if (pred_valid !== 1'b0) saw_valid = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      int n;
      logic [3:0] exp_bhr [5];
      logic       hist_out [5];
      logic       sat_taken [7];
      logic       sat_exp [7];

      reset         = 1'b1;
      pc            = '0;
      upd_bht_index = '0;
      upd_pht_index = '0;
      upd_taken     = 1'b0;
      idle();
      @(negedge clk);
      chk("rst_ready",      ready, 0);
      chk("rst_pred_valid", pred_valid, 0);
      chk("rst_perf_lk",    perf_lookups, 0);
      chk("rst_perf_mis",   perf_mispredicts, 0);
      reset = 1'b0;

      // Requests and mispredict updates during the sweep must be ignored.
      drive_pred(32'h0000_1234);
      drive_upd(4'd4, 7'h40, 1'b0, 1'b1);
      wait_sweep(n);
      idle();
      chk("sweep_len",        n, 128);
      chk("sweep_no_valid",   saw_valid, 0);
      chk("sweep_perf_lk",    perf_lookups, 0);
      chk("sweep_perf_mis",   perf_mispredicts, 0);

      drive_pred(32'h0000_1234);
      step();
      chk("first_valid", pred_valid, 1);
      chk("first_taken", pred_taken, 1);
      chk("first_bhr",   pred_bhr, 4'h0);
      chk("first_bht",   pred_bht_index, 4'h4);
      chk("first_pht",   pred_pht_index, 7'h40);
      step();
      chk("drop_valid",  pred_valid, 0);
      chk("hold_pht",    pred_pht_index, 7'h40);

      // Counter at 0x40: 2 -> 1,0,0,1,2,3,3 ; MSB gives 0,0,0,0,1,1,1.
      sat_taken = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      sat_exp   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
         drive_upd(4'd15, 7'h40, sat_taken[i], 1'b0);
         step();
         drive_pred(32'h0000_1234);
         step();
         chk($sformatf("sat_taken_%0d", i), pred_taken, sat_exp[i]);
      end

      // BHR forwarding: BHT[4] 0000 -> 0001 in the lookup cycle.
      drive_upd(4'd4, 7'h7F, 1'b1, 1'b0);
      drive_pred(32'h0000_1234);
      step();
      chk("fwd_bhr",   pred_bhr, 4'h1);
      chk("fwd_pht",   pred_pht_index, 7'h41);
      chk("fwd_taken", pred_taken, 1);

      // PHT forwarding: counter 0x41 taken to 1, then 1 -> 2 alongside the lookup.
      drive_upd(4'd15, 7'h41, 1'b0, 1'b0);
      step();
      drive_pred(32'h0000_1234);
      step();
      chk("pht_at_1_taken", pred_taken, 0);
      drive_upd(4'd15, 7'h41, 1'b1, 1'b0);
      drive_pred(32'h0000_1234);
      step();
      chk("fwd_ctr_pht",   pred_pht_index, 7'h41);
      chk("fwd_ctr_taken", pred_taken, 1);

      // Train 0x40 down to 0 so the post-reset INIT_CTR value is distinguishable.
      for (int i = 0; i < 3; i++) begin
         drive_upd(4'd15, 7'h40, 1'b0, 1'b0);
         step();
      end
      drive_pred(32'h0000_1234);
      step();
      chk("pre_rst_bht", pred_bht_index, 4'h4);

      n = 0;
      while (run_cycles < 300 && n < 2000) begin
         n++;
         @(negedge clk);
      end
      chk("run_300_reached", (run_cycles >= 300), 1);

      reset = 1'b1;
      drive_pred(32'h0000_1234);
      @(negedge clk);
      reset = 1'b0;
      idle();
      chk("mid_rst_ready",    ready, 0);
      chk("mid_rst_valid",    pred_valid, 0);
      chk("mid_rst_taken",    pred_taken, 0);
      chk("mid_rst_bht",      pred_bht_index, 0);
      chk("mid_rst_pht",      pred_pht_index, 0);
      chk("mid_rst_bhr",      pred_bhr, 0);
      chk("mid_rst_perf_lk",  perf_lookups, 0);
      chk("mid_rst_perf_mis", perf_mispredicts, 0);
      wait_sweep(n);
      idle();
      chk("sweep2_len", n, 128);

      drive_pred(32'h0000_1234);
      step();
      chk("cleared_bhr",   pred_bhr, 4'h0);
      chk("cleared_taken", pred_taken, 1);

      // History shift on BHT[4]: outcomes 1,0,1,1,1.
      hist_out = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_bhr  = '{4'b0001, 4'b0010, 4'b0101, 4'b1011, 4'b0111};
      for (int i = 0; i < 5; i++) begin
         drive_upd(4'd4, 7'h00, hist_out[i], 1'b0);
         step();
         drive_pred(32'h0000_1234);
         step();
         chk($sformatf("hist_bhr_%0d", i), pred_bhr, exp_bhr[i]);
      end
      chk("hist_pht", pred_pht_index, 7'h47);

      // Six lookups so far since reset; four more plus three mispredicts.
      for (int i = 0; i < 4; i++) begin
         drive_pred(32'h0000_2000 + 32'(i));
         step();
      end
      for (int i = 0; i < 3; i++) begin
         drive_upd(4'd15, 7'h7F, 1'b0, 1'b1);
         step();
      end
      drive_upd(4'd15, 7'h7F, 1'b1, 1'b0);
      step();
      chk("perf_lookups_10", perf_lookups, 10);
      chk("perf_mis_3",      perf_mispredicts, 3);

      force dut.perf_lookups_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.perf_lookups_q;
      chk("perf_forced", perf_lookups, 32'hFFFF_FFFF);
      drive_pred(32'h0000_1234);
      step();
      step();
      chk("perf_saturate", perf_lookups, 32'hFFFF_FFFF);
      chk("perf_mis_hold", perf_mispredicts, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
